ram_loader: RTL
===============

# ram_loader

Program loader that fills the 16x8 program RAM over the shared 8-bit bus before the CPU runs. It accepts 16 bytes on a valid/ready byte stream and writes them to addresses 0..15 using the RAM's write strobe. It then reads all 16 locations back with the RAM's read strobe and compares an 8-bit modular checksum. It holds the CPU off the bus for the whole sequence and reports done or error.

## Interface
- DEPTH, 16, number of RAM words loaded; fixed to match the 4-bit RAM address.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE and ERROR.
- byte_in  in  8  program byte from the host stream.
- byte_valid  in  1  byte_in holds a valid byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- ram_add_4  out  4  RAM address.
- ram_in  out  1  RAM write strobe; RAM captures ram_bus_8 on the rising edge while high.
- ram_out  out  1  RAM read strobe; RAM drives ram_bus_8 while high.
- ram_bus_8  inout  8  shared data bus; loader drives it only in WRITE, otherwise hi-Z.
- cpu_hold  out  1  keeps the CPU control unit off the bus while high.
- done  out  1  load and verify succeeded; sticky.
- error  out  1  verify checksum mismatch; sticky.
- checksum  out  8  modulo-256 sum of the bytes written.

## Operation
- All outputs are registered, including the bus-enable.
- States:
  - IDLE: waits for start; start -> WAIT_BYTE.
  - WAIT_BYTE: byte_ready=1. On byte_valid & byte_ready, latch byte_in into the data register, add it to wsum, go to WRITE.
  - WRITE: drive ram_bus_8 with the data register, ram_in=1, ram_add_4=ptr. Next state: if ptr==15, go to VERIFY with ptr wrapping to 0; else ptr+1 and go to WAIT_BYTE.
  - VERIFY: ram_out=1, ram_add_4=ptr. Sample ram_bus_8 at the end of the cycle and add it to rsum. If ptr==15, go to CHECK; else ptr+1.
  - CHECK: if rsum==wsum, go to DONE, else go to ERROR.
  - DONE: done=1, cpu_hold=0.
  - ERROR: error=1, cpu_hold stays 1.
- start in DONE or ERROR clears done, error, wsum, rsum and ptr, then enters WAIT_BYTE.
- start in any other state is ignored.
- cpu_hold=1 in every state except IDLE and DONE.
- checksum = wsum; it is held after DONE or ERROR until the next start.
- Invariants:
  - ram_in and ram_out are never high together.
  - The loader never drives the bus while ram_out=1.
  - byte_ready is high only in WAIT_BYTE.
- Sums are 8-bit and wrap modulo 256; carries are discarded.
- ptr is 4 bits and wraps 15 -> 0 only on the WRITE -> VERIFY transition.

## Timing
- Reset values:
  - state IDLE
  - byte_ready=0, ram_in=0, ram_out=0
  - bus hi-Z
  - ram_add_4=0, cpu_hold=0, done=0, error=0, checksum=0
  - internal ptr, wsum, rsum = 0
- Reset mid-operation:
  - Abort immediately and return to IDLE with the reset values above.
  - RAM contents already written are left as-is.
  - Any byte presented in the reset cycle is not accepted.
- With start sampled at cycle 0, WAIT_BYTE begins at cycle 1.
- Each byte costs 1 cycle (WAIT_BYTE) + 1 cycle (WRITE) minimum; stalls on byte_valid add cycles in WAIT_BYTE only.
- With no stalls:
  - writes occur at cycles 2,4,...,32
  - VERIFY covers cycles 33..48
  - CHECK at 49
  - done or error rises at cycle 50
- The verify read is single-cycle because RAM read data is combinational from the address while ram_out is high.
- Handshake: a byte transfers on a cycle where byte_valid and byte_ready are both 1. byte_valid with byte_ready=0 is held off with no loss.

## Test plan
- Reset, start, bytes 0x01..0x10 back-to-back:
  - ram_in pulses at cycles 2..32 even, addresses 0..15.
  - 16 ram_out cycles.
  - checksum=0x88, done=1 at cycle 50, cpu_hold falls at 50; RAM holds 0x01..0x10.
- Same stream with byte_valid deasserted 3 cycles before byte 5:
  - byte_ready stays high, no write occurs during the stall.
  - done is delayed to cycle 53; contents are unchanged from the previous case.
- Bus fault: the bench forces ram_bus_8 bit0 to 1 while ram_out=1 and ram_add_4=4, with byte 4 = 0x00 (all 16 bytes 0x00):
  - checksum=0x00, error=1, done=0, cpu_hold=1.
- start pulsed at cycle 10 and again at cycle 40 during a load:
  - both are ignored; the sequence and done timing are unchanged.
- rst asserted for one cycle after the write to address 7:
  - all outputs return to reset values on the next cycle; addresses 0..7 are retained.
  - A new start and a full load then complete normally.
- start in DONE with 16 bytes of 0xFF:
  - done clears at the next cycle.
  - checksum=0xF0 (wrap), done=1 again 50 cycles after start.

Source files
------------

// File: rtl/ram_loader.sv
// Loads 16 bytes from a valid/ready byte stream into the program RAM over the shared bus,
// reads them back, and flags done or error from an 8-bit modular checksum compare.
module ram_loader #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [3:0] ram_add_4,
  output logic       ram_in,
  output logic       ram_out,
  inout  wire  [7:0] ram_bus_8,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic [7:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_WRITE,
    S_VERIFY,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [3:0] LAST = 4'(DEPTH - 1);

  state_t     state;
  logic [3:0] ptr;
  logic [7:0] data;
  logic [7:0] wsum;
  logic [7:0] rsum;
  logic       bus_en;

  // Bus is driven only while the registered enable says WRITE; every other cycle it floats.
  assign ram_bus_8 = bus_en ? data : 8'hzz;
  assign checksum  = wsum;

  // Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both high;
  // byte_ready is a registered output that is high exactly while the FSM sits in WAIT_BYTE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= 4'd0;
      data       <= 8'd0;
      wsum       <= 8'd0;
      rsum       <= 8'd0;
      bus_en     <= 1'b0;
      byte_ready <= 1'b0;
      ram_add_4  <= 4'd0;
      ram_in     <= 1'b0;
      ram_out    <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_WAIT_BYTE;
            ptr        <= 4'd0;
            wsum       <= 8'd0;
            rsum       <= 8'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            ram_add_4  <= 4'd0;
          end
        end

        S_WAIT_BYTE: begin
          if (byte_valid && byte_ready) begin
            state      <= S_WRITE;
            data       <= byte_in;
            wsum       <= wsum + byte_in;
            byte_ready <= 1'b0;
            ram_in     <= 1'b1;
            bus_en     <= 1'b1;
            ram_add_4  <= ptr;
          end
        end

        S_WRITE: begin
          ram_in <= 1'b0;
          bus_en <= 1'b0;
          if (ptr == LAST) begin
            // Pointer wraps here and only here, so verify starts back at address 0.
            state     <= S_VERIFY;
            ptr       <= 4'd0;
            ram_out   <= 1'b1;
            ram_add_4 <= 4'd0;
          end else begin
            state      <= S_WAIT_BYTE;
            ptr        <= ptr + 4'd1;
            byte_ready <= 1'b1;
          end
        end

        S_VERIFY: begin
          // RAM read data is combinational from the address, so one cycle per word suffices.
          rsum <= rsum + ram_bus_8;
          if (ptr == LAST) begin
            state   <= S_CHECK;
            ram_out <= 1'b0;
          end else begin
            ptr       <= ptr + 4'd1;
            ram_add_4 <= ptr + 4'd1;
          end
        end

        S_CHECK: begin
          if (rsum == wsum) begin
            state    <= S_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
